// File: rtl/spi_display_arb_pkg.sv
// Shared types and constants for the spi_display command-stream arbiter.
package spi_display_arb_pkg;

   localparam int unsigned SPI_WORD_W = 9;
   localparam int unsigned BYTE_W     = SPI_WORD_W - 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              dc;
      logic [BYTE_W-1:0] data;
   } spi_word_t;

   // Index width for an N-way selector, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_display_arb_rr_pick.sv
// Combinational round-robin picker: first asserted req after pointer p, wrapping modulo N.
module spi_display_arb_rr_pick
   import spi_display_arb_pkg::*;
#(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] p,
   output logic          valid,
   output logic [IW-1:0] index
);

   int unsigned cand;

   // Scan from the farthest candidate down so the nearest one after p wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = 0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(p) + k) % N;
         if (req[cand]) begin
            valid = 1'b1;
            index = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/spi_display_arb.sv
// Transaction-locked round-robin arbiter sharing one spi_display source stream among N requesters.
// Optional stall-release watchdog enabled with `define SPI_ARB_TIMEOUT_EN.
module spi_display_arb
   import spi_display_arb_pkg::*;
#(
   parameter int unsigned N       = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N-1:0]        req_dc,
   input  logic [BYTE_W*N-1:0] req_data,
   input  logic [N-1:0]        req_last,
   input  logic [N-1:0]        req_empty,
   output logic [N-1:0]        req_get,
   output logic                out_dc,
   output logic [BYTE_W-1:0]   out_data,
   output logic                out_empty,
   input  logic                out_get,
   output logic [N-1:0]        grant,
   output logic                timeout
);

   localparam int unsigned IW = idx_w(N);

   if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
      $error("spi_display_arb: N must be 2..8 and TIMEOUT at least 1");
   end

   arb_state_t        state;
   logic [IW-1:0]     g;
   logic [IW-1:0]     p;
   logic              pick_valid;
   logic [IW-1:0]     pick_idx;
   logic              pop;
   spi_word_t         word;
   logic [BYTE_W-1:0] data_arr [N];

   spi_display_arb_rr_pick #(.N(N)) u_rr_pick (
      .req   (~req_empty),
      .p     (p),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_comb begin
      for (int i = 0; i < N; i++) begin
         data_arr[i] = req_data[BYTE_W*i +: BYTE_W];
      end
   end

   // Owner's source is forwarded straight through; idle looks like an empty FIFO.
   always_comb begin
      word      = '0;
      out_empty = 1'b1;
      req_get   = '0;
      if (state == ST_BUSY) begin
         word.dc    = req_dc[g];
         word.data  = data_arr[g];
         out_empty  = req_empty[g];
         req_get[g] = out_get & ~req_empty[g];
      end
   end

   assign out_dc   = word.dc;
   assign out_data = word.data;
   assign pop      = (state == ST_BUSY) & out_get & ~req_empty[g];

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] stall_cnt;
   logic             owner_empty;
   logic             stall_release;

   assign owner_empty   = (state == ST_BUSY) & req_empty[g];
   assign stall_release = owner_empty & (stall_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   // Grant is held from the first pop until the word flagged last leaves.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         g     <= '0;
         p     <= IW'(N - 1);
         grant <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         stall_cnt <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= ST_BUSY;
                  g     <= pick_idx;
                  grant <= N'(1) << pick_idx;
               end
            end
            ST_BUSY: begin
               if (pop && req_last[g]) begin
                  state <= ST_IDLE;
                  p     <= g;
                  grant <= '0;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (stall_release) begin
                  state   <= ST_IDLE;
                  p       <= g;
                  grant   <= '0;
                  timeout <= 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
`ifdef SPI_ARB_TIMEOUT_EN
         if (state != ST_BUSY || pop || stall_release) begin
            stall_cnt <= '0;
         end else if (owner_empty) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_spi_display_arb.sv
// Directed bench for spi_display_arb with two FIFO-style requesters and a popped-word log.
module tb_spi_display_arb;

   logic       clock;
   logic       reset;
   logic [1:0] req_dc;
   logic [15:0] req_data;
   logic [1:0] req_last;
   logic [1:0] req_empty;
   logic [1:0] req_get;
   logic       out_dc;
   logic [7:0] out_data;
   logic       out_empty;
   logic       out_get;
   logic [1:0] grant;
   logic       timeout;

   logic       auto_get;
   logic       force_get;
   logic [1:0] stall;
   logic [9:0] q0 [$];
   logic [9:0] q1 [$];
   logic [10:0] log_q [$];
   int         lp;
   int         n_checks;
   int         n_fail;

   spi_display_arb #(.N(2), .TIMEOUT(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_dc    (req_dc),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_empty (req_empty),
      .req_get   (req_get),
      .out_dc    (out_dc),
      .out_data  (out_data),
      .out_empty (out_empty),
      .out_get   (out_get),
      .grant     (grant),
      .timeout   (timeout)
   );

   assign out_get = force_get | (auto_get & ~out_empty);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic update_reqs();
      logic [9:0] w0;
      logic [9:0] w1;
      w0 = (q0.size() != 0) ? q0[0] : 10'h0;
      w1 = (q1.size() != 0) ? q1[0] : 10'h0;
      req_empty = {(q1.size() == 0) | stall[1], (q0.size() == 0) | stall[0]};
      req_last  = {w1[9], w0[9]};
      req_dc    = {w1[8], w0[8]};
      req_data  = {w1[7:0], w0[7:0]};
   endtask

   task automatic push(input int r, input logic last, input logic dc, input logic [7:0] data);
      if (r == 0) q0.push_back({last, dc, data});
      else        q1.push_back({last, dc, data});
      update_reqs();
   endtask

   // Advance one cycle: log what spi_display took, pop requester FIFOs, settle.
   task automatic tick();
      logic [1:0] got;
      logic       take;
      logic [10:0] entry;
      @(posedge clock);
      got   = req_get;
      take  = out_get & ~out_empty & ~reset;
      entry = {req_get, out_dc, out_data};
      #1;
      if (take) log_q.push_back(entry);
      if (got[0] && q0.size() != 0) void'(q0.pop_front());
      if (got[1] && q1.size() != 0) void'(q1.pop_front());
      update_reqs();
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && grant == 2'b00) && n < 60) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 60), 32'd1);
   endtask

   task automatic expect_log(input string tag, input int r, input logic dc, input logic [7:0] data);
      logic [10:0] exp;
      logic [10:0] got;
      exp = {(r == 0) ? 2'b01 : 2'b10, dc, data};
      got = (lp < log_q.size()) ? log_q[lp] : 11'h7FF;
      check(tag, 32'(got), 32'(exp));
      lp++;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      lp        = 0;
      reset     = 1'b1;
      auto_get  = 1'b0;
      force_get = 1'b0;
      stall     = 2'b00;
      update_reqs();
      tick();
      tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_empty", 32'(out_empty), 32'h1);
      check("rst_get", 32'(req_get), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);

      // 1: single requester, three-word transaction
      push(0, 1'b0, 1'b0, 8'h2A);
      push(0, 1'b0, 1'b1, 8'h00);
      push(0, 1'b1, 1'b1, 8'hEF);
      auto_get = 1'b1;
      reset    = 1'b0;
      tick();
      check("t1_grant", 32'(grant), 32'h1);
      check("t1_empty", 32'(out_empty), 32'h0);
      check("t1_d0", 32'(out_data), 32'h2A);
      check("t1_dc0", 32'(out_dc), 32'h0);
      check("t1_get0", 32'(req_get), 32'h1);
      tick();
      check("t1_d1", 32'(out_data), 32'h00);
      check("t1_dc1", 32'(out_dc), 32'h1);
      tick();
      check("t1_d2", 32'(out_data), 32'hEF);
      check("t1_get2", 32'(req_get), 32'h1);
      tick();
      check("t1_idle_grant", 32'(grant), 32'h0);
      check("t1_idle_empty", 32'(out_empty), 32'h1);
      check("t1_idle_get", 32'(req_get), 32'h0);
      expect_log("t1_log0", 0, 1'b0, 8'h2A);
      expect_log("t1_log1", 0, 1'b1, 8'h00);
      expect_log("t1_log2", 0, 1'b1, 8'hEF);

      // 2: simultaneous requests after reset, then again with p advanced
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int rep = 0; rep < 2; rep++) begin
         push(0, 1'b0, 1'b0, 8'h10);
         push(0, 1'b1, 1'b1, 8'h11);
         push(1, 1'b0, 1'b0, 8'h20);
         push(1, 1'b1, 1'b1, 8'h21);
         wait_drain("t2_drain");
         expect_log("t2_a0", 0, 1'b0, 8'h10);
         expect_log("t2_a1", 0, 1'b1, 8'h11);
         expect_log("t2_b0", 1, 1'b0, 8'h20);
         expect_log("t2_b1", 1, 1'b1, 8'h21);
      end

      // 3: owner stalls mid-transaction while the other requester waits
      push(1, 1'b0, 1'b0, 8'h30);
      push(1, 1'b0, 1'b1, 8'h31);
      push(1, 1'b1, 1'b1, 8'h32);
      tick();
      check("t3_grant", 32'(grant), 32'h2);
      check("t3_d0", 32'(out_data), 32'h30);
      tick();
      check("t3_d1", 32'(out_data), 32'h31);
      stall[1] = 1'b1;
      push(0, 1'b0, 1'b0, 8'h3A);
      push(0, 1'b1, 1'b1, 8'h3B);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_stall_grant", 32'(grant), 32'h2);
         check("t3_stall_empty", 32'(out_empty), 32'h1);
         check("t3_stall_get", 32'(req_get), 32'h0);
      end
      stall[1] = 1'b0;
      update_reqs();
      wait_drain("t3_drain");
      expect_log("t3_log0", 1, 1'b0, 8'h30);
      expect_log("t3_log1", 1, 1'b1, 8'h31);
      expect_log("t3_log2", 1, 1'b1, 8'h32);
      expect_log("t3_log3", 0, 1'b0, 8'h3A);
      expect_log("t3_log4", 0, 1'b1, 8'h3B);

      // 4: out_get held high while nothing is available
      auto_get  = 1'b0;
      force_get = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_idle_get", 32'(req_get), 32'h0);
         check("t4_idle_grant", 32'(grant), 32'h0);
      end
      push(0, 1'b0, 1'b0, 8'h40);
      tick();
      check("t4_grant", 32'(grant), 32'h1);
      check("t4_get", 32'(req_get), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_hold_get", 32'(req_get), 32'h0);
         check("t4_hold_grant", 32'(grant), 32'h1);
         check("t4_hold_empty", 32'(out_empty), 32'h1);
      end
      push(0, 1'b1, 1'b1, 8'h41);
      tick();
      check("t4_release", 32'(grant), 32'h0);
      force_get = 1'b0;
      expect_log("t4_log0", 0, 1'b0, 8'h40);
      expect_log("t4_log1", 0, 1'b1, 8'h41);

      // 5: reset while requester 1 owns the lock
      push(1, 1'b0, 1'b0, 8'h50);
      push(1, 1'b1, 1'b1, 8'h51);
      tick();
      check("t5_grant", 32'(grant), 32'h2);
      reset = 1'b1;
      tick();
      check("t5_rst_grant", 32'(grant), 32'h0);
      check("t5_rst_get", 32'(req_get), 32'h0);
      check("t5_rst_empty", 32'(out_empty), 32'h1);
      push(0, 1'b1, 1'b0, 8'h60);
      reset = 1'b0;
      tick();
      check("t5_winner", 32'(grant), 32'h1);
      auto_get = 1'b1;
      wait_drain("t5_drain");
      expect_log("t5_log0", 0, 1'b0, 8'h60);
      expect_log("t5_log1", 1, 1'b0, 8'h50);
      expect_log("t5_log2", 1, 1'b1, 8'h51);

`ifdef SPI_ARB_TIMEOUT_EN
      // 6: watchdog forces release after four stall cycles
      push(1, 1'b0, 1'b0, 8'h70);
      push(1, 1'b1, 1'b1, 8'h71);
      tick();
      check("t6_grant", 32'(grant), 32'h2);
      tick();
      stall[1] = 1'b1;
      push(0, 1'b1, 1'b0, 8'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_hold_grant", 32'(grant), 32'h2);
         check("t6_hold_to", 32'(timeout), 32'h0);
      end
      tick();
      check("t6_rel_grant", 32'(grant), 32'h0);
      check("t6_rel_to", 32'(timeout), 32'h1);
      tick();
      check("t6_next_grant", 32'(grant), 32'h1);
      check("t6_next_to", 32'(timeout), 32'h1);
      stall[1] = 1'b0;
      update_reqs();
      wait_drain("t6_drain");
      check("t6_sticky", 32'(timeout), 32'h1);
      expect_log("t6_log0", 1, 1'b0, 8'h70);
      expect_log("t6_log1", 0, 1'b0, 8'h80);
      expect_log("t6_log2", 1, 1'b1, 8'h71);
      reset = 1'b1;
      tick();
      check("t6_rst_to", 32'(timeout), 32'h0);
      reset = 1'b0;
      tick();
`else
      check("timeout_off", 32'(timeout), 32'h0);
`endif

      check("log_count", 32'(log_q.size()), 32'(lp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_display_arb.md
Name: spi_display_arb

Overview:
Transaction-level arbiter that shares one spi_display command stream among N requesters, e.g. an init/command ROM sequencer and a pixel/frame source.
- Each requester presents a FIFO-style source: dc, data, last, empty, with a get pop strobe.
- The arbiter presents the same source interface (dc, data, empty, get) to spi_display.
- Round-robin grant, locked per transaction until the word marked last is popped, so a command and its parameters are never interleaved with another requester's words.

Parameters:
- N, 2, number of requesters (2..8).
- TIMEOUT, 255, stall cycles before forced release; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_dc  in  N  per-requester D/C bit; bit i belongs to requester i.
- req_data  in  8*N  per-requester byte; slice [8i+7:8i] belongs to requester i.
- req_last  in  N  marks the current word as the final word of its transaction.
- req_empty  in  N  requester has no word available.
- req_get  out  N  pop strobe to the requester.
- out_dc  out  1  D/C bit to spi_display.
- out_data  out  8  byte to spi_display.
- out_empty  out  1  empty flag to spi_display.
- out_get  in  1  pop strobe from spi_display.
- grant  out  N  one-hot current owner; all zero when idle.
- timeout  out  1  sticky stall-release flag.

Behaviour:
- States: IDLE, BUSY. Grant index g and last-owner pointer p are registered.

Reset:
- state = IDLE, grant = 0, p = N-1, so requester 0 wins first.
- out_empty = 1, req_get = 0, timeout = 0.
- A reset mid-transaction drops the lock immediately. Partial-transaction recovery belongs to the requesters.

IDLE:
- If any req_empty[i] = 0, pick the first non-empty index searching p+1, p+2, … modulo N.
- Register it as g and go to BUSY.
- Arbitration latency: exactly 1 cycle from the request being visible to out_empty = 0.

BUSY, combinational forwarding:
- out_dc = req_dc[g], out_data = req_data[g], out_empty = req_empty[g].
- req_get[g] = out_get & ~req_empty[g]. All other req_get are 0.

BUSY, transitions:
- On out_get & ~req_empty[g] & req_last[g]: set p = g, go to IDLE next cycle.
- The following transaction's first word appears after the 1-cycle IDLE slot, including when the same requester continues.
- An empty owner mid-transaction keeps the lock; out_empty = 1 propagates the stall to spi_display.

Boundary conditions:
- out_get while out_empty = 1 (IDLE, or owner empty) is ignored: no req_get, no state change.
- Simultaneous requests are resolved purely by round-robin from p; no fixed priority.
- A single-word transaction (last on the first word) is legal and gives BUSY for one pop.
- Requesters that become non-empty while another owns the lock wait. Fairness bound: at most N-1 transactions ahead.
- grant is one-hot of g in BUSY and 0 in IDLE; it is registered.

Optional Feature:
Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on each pop and increments each BUSY cycle with req_empty[g] = 1.
  - On reaching TIMEOUT, the arbiter forces IDLE, sets p = g and sets timeout = 1.
  - timeout stays set until reset.
- Not defined: no counter; timeout is tied to 0; a stalled owner holds the lock indefinitely.

Decomposition:
- Shared package/constants:
  - SPI_WORD_W = 9, the {dc, data} word width.
  - State encodings ST_IDLE = 0, ST_BUSY = 1.
- One natural sub-module: rr_pick. Combinational round-robin picker with inputs req[N] and p, outputs valid and index.
- Forwarding mux and FSM stay in spi_display_arb.

Test Plan:
1. Reset, then req0 holds 3 words {0,0x2A},{1,0x00},{1,0xEF, last}, req1 empty, out_get pulsed each non-empty cycle:
   - grant = 01 one cycle after reset release.
   - out shows 0x2A, 0x00, 0xEF in order with req_get[0] ×3.
   - Then IDLE, grant = 00.
2. Both requesters non-empty at once, each with 2-word transactions:
   - Order is req0 transaction then req1 transaction.
   - No req1 word appears before req0's last word.
   - Repeating the stimulus gives req0 then req1 again (p advances).
3. req1 transaction stalls (req_empty[1] = 1 for 10 cycles mid-transaction) while req0 is non-empty:
   - grant stays 10 and out_empty = 1 throughout.
   - No req_get[0].
   - Transaction resumes and completes when req1 refills.
4. out_get held high in IDLE and during owner-empty cycles:
   - No req_get asserted and no state change.
5. Reset asserted while grant = 10 mid-transaction:
   - Next cycle grant = 00, req_get = 0, out_empty = 1.
   - After release with both requesting, req0 wins.
6. With SPI_ARB_TIMEOUT_EN and TIMEOUT = 4, owner empty mid-transaction:
   - Release on the 4th stall cycle, with timeout = 1 from that point on.
   - Other requester granted next; timeout stays 1 until reset.
